// File: rtl/shift_add_multiplier.sv
// Sequential unsigned N x N -> 2N shift-add multiplier with valid/ready handshakes on both sides.
// The partial-product accumulator is a single ripple-carry adder_n instance.

module adder_n #(
   parameter int N = 32
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         c_in,
   output logic [N-1:0] sum,
   output logic         c_out
);

   logic [N:0] carry;

   assign carry[0] = c_in;

   for (genvar i = 0; i < N; i++) begin : g_fa
      assign sum[i]       = a[i] ^ b[i] ^ carry[i];
      assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
   end

   assign c_out = carry[N];

endmodule

module shift_add_multiplier #(
   parameter int N = 32
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           i_valid,
   output logic           i_ready,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic           o_valid,
   input  logic           o_ready,
   output logic [2*N-1:0] product,
   output logic           busy
);

   localparam int                CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0]  LAST  = CNT_W'(N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [N-1:0]     mcand;
   logic [2*N-1:0]   acc;
   logic [2*N-1:0]   acc_nxt;
   logic [N-1:0]     addend;
   logic [N-1:0]     sum;
   logic             c_out;
   logic             accept;
   logic             last_step;

   assign accept    = (state == IDLE) && i_valid;
   assign last_step = (state == RUN) && (cnt == LAST);

   // One step: add the multiplicand into the upper half when the current LSB is set,
   // then shift the 2N+1-bit {carry, sum, lower half} right by one.
   assign addend  = acc[0] ? mcand : '0;
   assign acc_nxt = {c_out, sum, acc[N-1:1]};

   adder_n #(
      .N(N)
   ) u_acc_add (
      .a    (acc[2*N-1:N]),
      .b    (addend),
      .c_in (1'b0),
      .sum  (sum),
      .c_out(c_out)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (i_valid)   state_nxt = RUN;
         RUN:     if (last_step) state_nxt = DONE;
         DONE:    if (o_ready)   state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   always_comb begin
      i_ready = 1'b0;
      o_valid = 1'b0;
      busy    = 1'b0;
      case (state)
         IDLE:    i_ready = 1'b1;
         RUN:     busy    = 1'b1;
         DONE:    o_valid = 1'b1;
         default: i_ready = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (accept || last_step) begin
         cnt <= '0;
      end else if (state == RUN) begin
         cnt <= cnt + 1'b1;
      end
   end

   // Working registers carry no reset: they are only observable through product,
   // which is loaded exclusively on the final step of an uninterrupted operation.
   always_ff @(posedge clk) begin
      if (accept) begin
         mcand <= a;
         acc   <= {{N{1'b0}}, b};
      end else if (state == RUN) begin
         acc   <= acc_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         product <= '0;
      end else if (last_step) begin
         product <= acc_nxt;
      end
   end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier: stimulus pushes expected products,
// a negedge monitor pops and compares on every output handshake.

module tb_shift_add_multiplier;

   localparam int N = 32;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           i_valid = 1'b0;
   logic           i_ready;
   logic [N-1:0]   a = '0;
   logic [N-1:0]   b = '0;
   logic           o_valid;
   logic           o_ready = 1'b1;
   logic [2*N-1:0] product;
   logic           busy;

   typedef struct {
      logic [2*N-1:0] prod;
      int             acc_cyc;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc   = 0;
   logic ov_q  = 1'b0;

   shift_add_multiplier #(.N(N)) dut (
      .clk    (clk),
      .rst    (rst),
      .i_valid(i_valid),
      .i_ready(i_ready),
      .a      (a),
      .b      (b),
      .o_valid(o_valid),
      .o_ready(o_ready),
      .product(product),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [2*N-1:0] act, input logic [2*N-1:0] exp_v);
      n_vec++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp_v);
      end
   endtask

   // Monitor: values are stable at the negedge until the next rising edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (o_valid && !ov_q) begin
            if (sb.size() > 0)
               check("latency", 64'(cyc), 64'(sb[0].acc_cyc + N));
            else
               check("unexpected_o_valid", 64'(o_valid), 64'd0);
         end
         if (o_valid && o_ready && sb.size() > 0) begin
            check("product", product, sb[0].prod);
            void'(sb.pop_front());
         end
      end
      ov_q = o_valid && !rst;
   end

   task automatic issue(input logic [N-1:0] ta, input logic [N-1:0] tb_v, input logic [2*N-1:0] exp_v);
      int guard = 0;
      while (!i_ready && guard < 200) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!i_ready) check("issue_timeout", 64'(i_ready), 64'd1);
      a       = ta;
      b       = tb_v;
      i_valid = 1'b1;
      @(posedge clk); #1;
      sb.push_back('{exp_v, cyc});
      i_valid = 1'b0;
   endtask

   task automatic drain();
      int guard = 0;
      while ((sb.size() != 0 || !i_ready) && guard < 200) begin
         @(posedge clk); #1;
         guard++;
      end
      if (sb.size() != 0 || !i_ready) begin
         check("drain_timeout", 64'(sb.size()), 64'd0);
         sb.delete();
      end
   endtask

   initial begin
      #2;
      check("rst_i_ready", 64'(i_ready), 64'd1);
      check("rst_o_valid", 64'(o_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_product", product, 64'd0);
      #21 rst = 1'b0;
      @(posedge clk); #1;

      // Basic and carry-heavy products.
      issue(32'd3, 32'd5, 64'd15);
      drain();
      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
      drain();
      issue(32'h0, 32'h1234_5678, 64'h0);
      issue(32'h1, 32'hA004_0002, 64'h0000_0000_A004_0002);
      drain();

      // Back-pressure in DONE, with operand noise that must be ignored.
      o_ready = 1'b0;
      issue(32'd7, 32'd6, 64'd42);
      begin
         int guard = 0;
         while (!o_valid && guard < 100) begin
            @(posedge clk); #1;
            guard++;
         end
      end
      for (int i = 0; i < 5; i++) begin
         check("hold_o_valid", 64'(o_valid), 64'd1);
         check("hold_product", product, 64'd42);
         check("hold_i_ready", 64'(i_ready), 64'd0);
         a       = 32'hDEAD_0000 + 32'(i);
         b       = 32'h0000_BEEF;
         i_valid = 1'b1;
         @(posedge clk); #1;
      end
      i_valid = 1'b0;
      o_ready = 1'b1;
      @(posedge clk); #1;
      check("release_i_ready", 64'(i_ready), 64'd1);
      check("release_o_valid", 64'(o_valid), 64'd0);
      check("release_product", product, 64'd42);
      drain();

      // Asynchronous reset in the middle of an operation.
      issue(32'd100, 32'd200, 64'd20000);
      repeat (10) @(posedge clk);
      #3;
      check("mid_run_busy", 64'(busy), 64'd1);
      rst = 1'b1;
      #1;
      check("arst_product", product, 64'd0);
      check("arst_i_ready", 64'(i_ready), 64'd1);
      check("arst_o_valid", 64'(o_valid), 64'd0);
      check("arst_busy", 64'(busy), 64'd0);
      sb.delete();
      #2 rst = 1'b0;
      @(posedge clk); #1;
      issue(32'd9, 32'd9, 64'd81);
      drain();

      // New operands during RUN must not disturb the accepted pair.
      issue(32'h0000_1234, 32'h0000_5678, 64'h0000_0000_0626_0060);
      for (int i = 0; i < 6; i++) begin
         a       = 32'hFFFF_0000 | 32'(i);
         b       = 32'h0F0F_0F0F;
         i_valid = i[0];
         @(posedge clk); #1;
      end
      i_valid = 1'b0;
      drain();

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
